// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog AXI slave: register offsets, response codes,
// channel FSM state types and small decode/merge helpers.
package wdt_pkg;

  localparam logic [11:0] WDEN_OFS    = 12'h100;
  localparam logic [11:0] WDLIVE_OFS  = 12'h200;
  localparam logic [11:0] WTOCNT_OFS  = 12'h300;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic is_mapped(input logic [11:0] ofs);
    return (ofs == WDEN_OFS) || (ofs == WDLIVE_OFS) || (ofs == WTOCNT_OFS);
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wdt_counter.sv
// Watchdog timeout counter with compare and sticky timeout flag.
// Optional prescaler selected by WDT_PRESCALE_EN.
module wdt_counter
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_BITS = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                kick,
  input  logic [CNT_BITS-1:0] wtocnt,
  output logic                wto
);

  logic [CNT_BITS-1:0] cnt;
  logic                tick;
  logic                over;

`ifdef WDT_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              pre <= '0;
    else if (!en || kick || pre == PRE_MAX) pre <= '0;
    else                                   pre <= pre + PW'(1);
  end

  assign tick = en && (pre == PRE_MAX);
`else
  localparam int unsigned prescale_unused = PRESCALE;

  assign tick = en;
`endif

  assign over = (cnt > wtocnt);

  // Counter freezes once past the compare value (or at all-ones) so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (!en || kick)                      cnt <= '0;
    else if (tick && !over && (cnt != '1))     cnt <= cnt + CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             wto <= 1'b0;
    else if (!en || kick) wto <= 1'b0;
    else if (over)        wto <= 1'b1;
  end

endmodule

// File: rtl/wdt_axi_slave.sv
// AXI4 slave exposing the watchdog registers WDEN/WDLIVE/WTOCNT and the timeout interrupt.
// Build option: WDT_PRESCALE_EN (prescaled counter ticks, see wdt_counter).
module wdt_axi_slave
  import wdt_pkg::*;
#(
  parameter int unsigned IDS_BITS = 8,
  parameter int unsigned CNT_BITS = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDS_BITS-1:0] ARID_S,
  input  logic [31:0]         ARADDR_S,
  input  logic [3:0]          ARLEN_S,
  input  logic [2:0]          ARSIZE_S,
  input  logic [1:0]          ARBURST_S,
  input  logic                ARVALID_S,
  output logic                ARREADY_S,
  output logic [IDS_BITS-1:0] RID_S,
  output logic [31:0]         RDATA_S,
  output logic [1:0]          RRESP_S,
  output logic                RLAST_S,
  output logic                RVALID_S,
  input  logic                RREADY_S,
  input  logic [IDS_BITS-1:0] AWID_S,
  input  logic [31:0]         AWADDR_S,
  input  logic [3:0]          AWLEN_S,
  input  logic [2:0]          AWSIZE_S,
  input  logic [1:0]          AWBURST_S,
  input  logic                AWVALID_S,
  output logic                AWREADY_S,
  input  logic [31:0]         WDATA_S,
  input  logic [3:0]          WSTRB_S,
  input  logic                WLAST_S,
  input  logic                WVALID_S,
  output logic                WREADY_S,
  output logic [IDS_BITS-1:0] BID_S,
  output logic [1:0]          BRESP_S,
  output logic                BVALID_S,
  input  logic                BREADY_S,
  output logic                WTO_interrupt
);

  // Holds both address channels not-ready while in reset and for the first edge after it.
  logic ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  logic                wden;
  logic [CNT_BITS-1:0] wtocnt;
  logic                kick;

  r_state_t            r_state, r_next;
  logic [IDS_BITS-1:0] ar_id;
  logic [11:0]         ar_addr;
  logic [3:0]          ar_len;
  logic [3:0]          beat;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic [11:0]         rd_sel;
  logic [31:0]         rd_value;
  logic                ar_hs, r_hs, r_last;

  w_state_t            w_state, w_next;
  logic [IDS_BITS-1:0] aw_id;
  logic [11:0]         aw_addr;
  logic [1:0]          bresp;
  logic                aw_hs, w_hs;

  logic unused_bits;
  assign unused_bits = ^{ARADDR_S[31:12], ARSIZE_S, ARBURST_S,
                         AWADDR_S[31:12], AWLEN_S, AWSIZE_S, AWBURST_S};

  // Read mux: the AR address in the handshake cycle, the latched one afterwards.
  always_comb begin
    rd_sel   = (r_state == R_IDLE) ? ARADDR_S[11:0] : ar_addr;
    rd_value = '0;
    case (rd_sel)
      WDEN_OFS:   rd_value = {31'b0, wden};
      WTOCNT_OFS: rd_value = 32'(wtocnt);
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ARVALID_S && ready_q) r_next = R_DATA;
      R_DATA:  if (RREADY_S && r_last)   r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY_S = (r_state == R_IDLE) && ready_q;
    RVALID_S  = (r_state == R_DATA);
    r_last    = (r_state == R_DATA) && (beat == ar_len);
    RLAST_S   = r_last;
    ar_hs     = ARVALID_S && ARREADY_S;
    r_hs      = RVALID_S && RREADY_S;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_id   <= '0;
      ar_addr <= '0;
      ar_len  <= '0;
      beat    <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      ar_id   <= ARID_S;
      ar_addr <= ARADDR_S[11:0];
      ar_len  <= ARLEN_S;
      beat    <= '0;
      rdata   <= rd_value;
      rresp   <= is_mapped(ARADDR_S[11:0]) ? RESP_OKAY : RESP_DECERR;
    end else if (r_hs && !r_last) begin
      beat    <= beat + 4'd1;
      rdata   <= rd_value;
    end
  end

  assign RID_S   = ar_id;
  assign RDATA_S = rdata;
  assign RRESP_S = rresp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (AWVALID_S && ready_q) w_next = W_DATA;
      W_DATA:  if (WVALID_S && WLAST_S)  w_next = W_RESP;
      W_RESP:  if (BREADY_S)             w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY_S = (w_state == W_IDLE) && ready_q;
    WREADY_S  = (w_state == W_DATA);
    BVALID_S  = (w_state == W_RESP);
    aw_hs     = AWVALID_S && AWREADY_S;
    w_hs      = WVALID_S && WREADY_S;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_id   <= '0;
      aw_addr <= '0;
      bresp   <= RESP_OKAY;
    end else if (aw_hs) begin
      aw_id   <= AWID_S;
      aw_addr <= AWADDR_S[11:0];
      bresp   <= is_mapped(AWADDR_S[11:0]) ? RESP_OKAY : RESP_DECERR;
    end
  end

  assign BID_S   = aw_id;
  assign BRESP_S = bresp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wden   <= 1'b0;
      wtocnt <= '0;
    end else if (w_hs) begin
      case (aw_addr)
        WDEN_OFS:   if (WSTRB_S[0]) wden <= WDATA_S[0];
        WTOCNT_OFS: wtocnt <= CNT_BITS'(strb_merge(32'(wtocnt), WDATA_S, WSTRB_S));
        default:    ;
      endcase
    end
  end

  assign kick = w_hs && (aw_addr == WDLIVE_OFS) && WSTRB_S[0] && WDATA_S[0];

  wdt_counter #(
    .CNT_BITS (CNT_BITS),
    .PRESCALE (PRESCALE)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (wden),
    .kick   (kick),
    .wtocnt (wtocnt),
    .wto    (WTO_interrupt)
  );

endmodule

// File: tb/tb_wdt_axi_slave.sv
// Scoreboard bench for wdt_axi_slave: expected R/B responses are queued when requests
// are issued and checked as the DUT returns them; interrupt timing checked in cycles.
module tb_wdt_axi_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ARID_S = '0, AWID_S = '0, RID_S, BID_S;
  logic [31:0] ARADDR_S = '0, AWADDR_S = '0, WDATA_S = '0, RDATA_S;
  logic [3:0]  ARLEN_S = '0, AWLEN_S = '0, WSTRB_S = '0;
  logic [2:0]  ARSIZE_S = 3'd2, AWSIZE_S = 3'd2;
  logic [1:0]  ARBURST_S = 2'd1, AWBURST_S = 2'd1, RRESP_S, BRESP_S;
  logic        ARVALID_S = 1'b0, AWVALID_S = 1'b0, WVALID_S = 1'b0, WLAST_S = 1'b0;
  logic        RREADY_S = 1'b0, BREADY_S = 1'b0;
  logic        ARREADY_S, RLAST_S, RVALID_S, AWREADY_S, WREADY_S, BVALID_S, WTO_interrupt;

  wdt_axi_slave #(.IDS_BITS(8), .CNT_BITS(32), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .WTO_interrupt(WTO_interrupt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
  rexp_t r_q[$];
  bexp_t b_q[$];

  logic        m_wden   = 1'b0;
  logic [31:0] m_wtocnt = '0;
  int unsigned last_w_cyc;
  logic        wto_after_w;

  logic [58:0] out_vec;
  assign out_vec = {ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
                    AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S, WTO_interrupt};

  function automatic logic [1:0] model_resp(input logic [11:0] a);
    return (a == 12'h100 || a == 12'h200 || a == 12'h300) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h100) return {31'b0, m_wden};
    if (a == 12'h300) return m_wtocnt;
    return 32'h0;
  endfunction

  task automatic timeout_fail(input string what);
    n_tests++; n_fail++;
    $display("FAIL %s: handshake not seen within cycle budget", what);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [7:0] id);
    bexp_t be;
    bit ok;
    be.id = id; be.resp = model_resp(addr[11:0]);
    b_q.push_back(be);
    if (addr[11:0] == 12'h100 && strb[0]) m_wden = data[0];
    if (addr[11:0] == 12'h300)
      for (int i = 0; i < 4; i++) if (strb[i]) m_wtocnt[i*8 +: 8] = data[i*8 +: 8];

    @(posedge clk); #1;
    AWVALID_S = 1'b1; AWADDR_S = addr; AWID_S = id; AWLEN_S = 4'd0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWREADY_S) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
    if (!ok) timeout_fail("aw_handshake");

    WVALID_S = 1'b1; WDATA_S = data; WSTRB_S = strb; WLAST_S = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (WREADY_S) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    last_w_cyc = cyc;
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    if (!ok) timeout_fail("w_handshake");

    BREADY_S = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) wto_after_w = WTO_interrupt;
      if (BVALID_S) begin ok = 1; break; end
    end
    if (ok && b_q.size() > 0) begin
      be = b_q.pop_front();
      n_tests++;
      if ({BID_S, BRESP_S} !== {be.id, be.resp}) begin
        n_fail++;
        $display("FAIL b_resp @%h: got id=%h resp=%b, expected id=%h resp=%b",
                 addr, BID_S, BRESP_S, be.id, be.resp);
      end
    end else timeout_fail("b_response");
    @(posedge clk); #1;
    BREADY_S = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] id,
                          input logic [3:0] len, input bit toggle);
    rexp_t re;
    bit ok;
    int beats;
    for (int b = 0; b <= int'(len); b++) begin
      re.id = id; re.data = model_read(addr[11:0]); re.resp = model_resp(addr[11:0]);
      re.last = (b == int'(len));
      r_q.push_back(re);
    end

    @(posedge clk); #1;
    ARVALID_S = 1'b1; ARADDR_S = addr; ARID_S = id; ARLEN_S = len;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARREADY_S) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
    if (!ok) timeout_fail("ar_handshake");

    beats = 0;
    for (int k = 0; k < 64 && beats <= int'(len); k++) begin
      RREADY_S = toggle ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (RVALID_S !== 1'b1) begin
          n_fail++;
          $display("FAIL first_rvalid @%h: got %b, expected 1 one cycle after AR", addr, RVALID_S);
        end
      end
      if (RVALID_S && r_q.size() > 0) begin
        re = r_q[0];
        n_tests++;
        if ({RID_S, RDATA_S, RRESP_S, RLAST_S} !== {re.id, re.data, re.resp, re.last}) begin
          n_fail++;
          $display("FAIL %s @%h beat %0d: got id=%h data=%h resp=%b last=%b, expected id=%h data=%h resp=%b last=%b",
                   RREADY_S ? "r_beat" : "r_stall", addr, beats, RID_S, RDATA_S, RRESP_S, RLAST_S,
                   re.id, re.data, re.resp, re.last);
        end
        if (RREADY_S) begin
          void'(r_q.pop_front());
          beats++;
        end
      end
      @(posedge clk); #1;
    end
    RREADY_S = 1'b0;
    if (beats != int'(len) + 1) begin
      timeout_fail("r_beats");
      r_q.delete();
    end
  endtask

  task automatic wait_wto_rise(input int unsigned exp_delta, input int unsigned ref_cyc,
                               input string what);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (WTO_interrupt) begin ok = 1; break; end
    end
    if (ok) begin
      n_tests++;
      if (cyc - ref_cyc !== exp_delta) begin
        n_fail++;
        $display("FAIL %s: WTO rose %0d cycles after handshake, expected %0d", what, cyc - ref_cyc, exp_delta);
      end
    end else timeout_fail(what);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", out_vec);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, WTO_interrupt} !== 6'b110000) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b, expected 110000",
               {ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, WTO_interrupt});
    end
  endtask

  task automatic test_timeout;
    axi_write(32'h300, 32'd5, 4'hF, 8'h11);
    axi_write(32'h100, 32'd1, 4'hF, 8'h12);
    wait_wto_rise(7, last_w_cyc, "wto_rise");
  endtask

  task automatic test_kick;
    n_tests++;
    if (WTO_interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL wto_before_kick: got %b, expected 1", WTO_interrupt);
    end
    axi_write(32'h200, 32'd1, 4'hF, 8'h21);
    n_tests++;
    if (wto_after_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wto_after_kick: got %b, expected 0", wto_after_w);
    end
    wait_wto_rise(7, last_w_cyc, "wto_rekick");
  endtask

  task automatic test_read_burst;
    axi_read(32'h300, 8'h5A, 4'd3, 1'b1);
  endtask

  task automatic test_decerr;
    axi_write(32'h040, 32'hDEADBEEF, 4'hF, 8'h33);
    axi_read(32'h040, 8'h34, 4'd0, 1'b0);
    axi_read(32'h300, 8'h35, 4'd0, 1'b0);
    axi_read(32'h100, 8'h36, 4'd0, 1'b0);
    axi_read(32'h200, 8'h37, 4'd0, 1'b0);
  endtask

  task automatic test_strobe;
    axi_write(32'h100, 32'd0, 4'hF, 8'h41);
    axi_write(32'h300, 32'd0, 4'hF, 8'h42);
    axi_write(32'h300, 32'hAABBCC10, 4'b0001, 8'h43);
    axi_read(32'h300, 8'h44, 4'd0, 1'b0);
    n_tests++;
    if (WTO_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL wto_disabled: got %b, expected 0", WTO_interrupt);
    end
  endtask

  task automatic test_reset_midburst;
    bit ok;
    bit seen_b;
    axi_write(32'h300, 32'd0, 4'hF, 8'h51);
    axi_write(32'h100, 32'd1, 4'hF, 8'h52);
    wait_wto_rise(2, last_w_cyc, "wto_rise_zero_cmp");

    @(posedge clk); #1;
    AWVALID_S = 1'b1; AWADDR_S = 32'h300; AWID_S = 8'hC3; AWLEN_S = 4'd3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AWREADY_S) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
    if (!ok) timeout_fail("burst_aw_handshake");
    WVALID_S = 1'b1; WDATA_S = 32'h1234; WSTRB_S = 4'hF; WLAST_S = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (WREADY_S) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) timeout_fail("burst_w_handshake");
    WDATA_S = 32'h5678;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (out_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_midburst_outputs: got %h, expected 0", out_vec);
    end
    m_wden = 1'b0; m_wtocnt = '0;
    WVALID_S = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    BREADY_S = 1'b1;
    seen_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (BVALID_S) seen_b = 1;
    end
    BREADY_S = 1'b0;
    n_tests++;
    if (seen_b !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_bvalid: got BVALID=1 after reset, expected 0");
    end
    axi_write(32'h300, 32'd7, 4'hF, 8'h61);
    axi_read(32'h300, 8'h62, 4'd0, 1'b0);
    axi_read(32'h100, 8'h63, 4'd0, 1'b0);
    n_tests++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got b=%0d r=%0d pending, expected 0 0", b_q.size(), r_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_timeout();
    test_kick();
    test_read_burst();
    test_decerr();
    test_strobe();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_axi_slave.md
Name: wdt_axi_slave

Overview:
- AXI4 slave (responder) that plugs into a slave port of the system AXI interconnect.
- Exposes a watchdog timer through three memory-mapped registers and drives the system watchdog-timeout interrupt (WTO_interrupt).
- Responds to AR/R and AW/W/B transactions issued through the interconnect by CPU-side masters; the read and write channel state machines are independent.

Parameters:
- IDS_BITS, 8, slave-side ID width (master ID plus master index)
- CNT_BITS, 32, width of timeout counter and WTOCNT register
- PRESCALE, 4, clock divide ratio for counter ticks; used only with WDT_PRESCALE_EN

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  in  IDS_BITS/32/4/3/2/1  read address channel
- ARREADY_S  out  1  read address ready
- RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  out  IDS_BITS/32/2/1/1  read data channel
- RREADY_S  in  1  read data ready
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  in  IDS_BITS/32/4/3/2/1  write address channel
- AWREADY_S  out  1  write address ready
- WDATA_S/WSTRB_S/WLAST_S/WVALID_S  in  32/4/1/1  write data channel
- WREADY_S  out  1  write data ready
- BID_S/BRESP_S/BVALID_S  out  IDS_BITS/2/1  write response channel
- BREADY_S  in  1  write response ready
- WTO_interrupt  out  1  watchdog timeout, level

Behaviour:
- Reset (rst=0, async): all outputs 0; WDEN=0, WDLIVE=0, WTOCNT=0, counter=0; both FSMs to IDLE. Reset mid-burst abandons the transaction; no response is issued.
- Register map, decoded on ADDR[11:0]:
  - 0x100 WDEN: bit0, RW.
  - 0x200 WDLIVE: bit0, write-1 kick; reads 0.
  - 0x300 WTOCNT: CNT_BITS, RW.
  - Any other offset: reads 0 with RRESP=2'b11 (DECERR); writes ignored with BRESP=2'b11. Mapped offsets return 2'b00.
- Read FSM:
  - R_IDLE: ARREADY_S=1. On ARVALID&ARREADY, latch ID, address and LEN, beat count=0, go to R_DATA.
  - R_DATA: ARREADY_S=0, RVALID_S=1. RDATA_S is the registered read value, sampled in the AR handshake cycle and re-sampled after each beat. RLAST_S=1 when beat==LEN. On RVALID&RREADY: if last, go to R_IDLE; else beat+1.
  - All burst beats address the same register (FIXED semantics regardless of ARBURST). First RVALID appears one cycle after the AR handshake.
  - RVALID_S and RDATA_S hold stable while RREADY_S=0.
- Write FSM:
  - W_IDLE: AWREADY_S=1. On the AW handshake, latch ID and address, go to W_DATA.
  - W_DATA: WREADY_S=1. Each W handshake writes the register, honouring WSTRB byte lanes. On WLAST_S, go to W_RESP.
  - W_RESP: BVALID_S=1, held until BREADY_S, then go to W_IDLE.
  - Writes take effect the cycle after the W handshake.
- Counter:
  - WDEN=0: counter holds 0, WTO_interrupt=0.
  - WDEN=1: counter increments by 1 per tick (a tick is every clk).
  - When counter > WTOCNT: WTO_interrupt=1 and the counter saturates.
  - WTO_interrupt clears only on WDEN=0 or a WDLIVE kick.
- Kick: a write of 1 to WDLIVE resets the counter to 0 and clears WTO_interrupt the next cycle. If a kick and a tick coincide, the kick wins.
- WTOCNT write while enabled: counter is not reset; the new compare value applies the next cycle.
- Simultaneous read and write: both FSMs proceed concurrently. A read of a register in the same cycle as a write to it returns the old value.

Optional Feature:
- WDT_PRESCALE_EN defined: an internal prescaler generates a tick every PRESCALE clk cycles. The prescaler resets on WDEN=0 and on a kick.
- Not defined: tick every cycle; PRESCALE ignored, no prescaler logic.

Decomposition:
- Package wdt_pkg:
  - offsets WDEN_OFS=12'h100, WDLIVE_OFS=12'h200, WTOCNT_OFS=12'h300
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11
  - enums r_state_t {R_IDLE,R_DATA} and w_state_t {W_IDLE,W_DATA,W_RESP}
- Sub-module wdt_counter: counter, prescaler, compare and sticky WTO logic. Inputs: en, kick, wtocnt. Output: wto.

Test Plan:
- Reset, then single write WTOCNT=5 (AWLEN=0), then WDEN=1 -> BRESP=00. WTO_interrupt rises 7 cycles after the WDEN write handshake (counter reaches 6); without prescale.
- With WTO asserted, write WDLIVE=1 -> WTO_interrupt=0 next cycle, counter=0. Re-asserts after WTOCNT+1 further ticks.
- Read burst ARLEN=3 at 0x300, RREADY toggling 1,0,1,0 -> 4 beats of 0x00000005, RLAST only on beat 4, RID equal to ARID, data stable during stalls.
- Write to 0x040 with WSTRB=4'hF, then read 0x040 -> BRESP=11, RRESP=11, RDATA=0. Register state unchanged.
- Write WTOCNT with WSTRB=4'b0001, data 0xAABBCC10, over a prior value of 0 -> WTOCNT=0x00000010.
- Assert rst low mid write burst (after beat 1 of 4) -> all outputs 0 immediately. After release, a new AW is accepted and no stale BVALID appears.
